ps2_kbd_rx: RTL

- PS/2 keyboard receiver on the board's `kbd[1:0]` pins: `kbd[0]` is the PS/2 clock, `kbd[1]` is the PS/2 data.
- Upstream stage of the CPU input path. Decodes scan-code frames, including the E0 (extended) and F0 (break) prefixes, into a held key code plus a one-cycle valid strobe.
- Top level feeds `{6'b0, code}` into the CPU `in` port in place of the switches.
- Runs on the fast board clock, not the divided CPU clock.

---
 rtl/ps2_kbd_rx_pkg.sv | 28 ++
 rtl/ps2_frame_rx.sv | 109 ++++++++++
 rtl/ps2_kbd_rx.sv | 68 ++++++
 3 files changed

// File: rtl/ps2_kbd_rx_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver.
// Prefix bytes, frame FSM state encoding and key-code field layout.
package ps2_kbd_rx_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int BRK_BIT = 9;
    localparam int EXT_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    function automatic logic [9:0] make_code(input logic brk, input logic ext,
                                             input logic [7:0] scan);
        logic [9:0] c;
        c          = '0;
        c[BRK_BIT] = brk;
        c[EXT_BIT] = ext;
        c[7:0]     = scan;
        return c;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, frame FSM
// and inter-edge watchdog. Emits one received byte or one error per frame.
module ps2_frame_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int TIMEOUT     = 100_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_ok,
    output logic [7:0] rx_byte,
    output logic       err,
    output logic       busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fe;

    ps2_state_t      state_q, state_d;
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt;
    logic            par_q;
    logic [WD_W-1:0] wd_q;
    logic            timeout;
    logic            frame_ok;

    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        return (v == WD_MAX) ? v : v + 1'b1;
    endfunction

    // Synchroniser stage: both lines idle high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fe       = clk_prev & ~clk_s;
    assign frame_ok = data_s & (^{shift_q, par_q});
    // A falling edge in the match cycle keeps the frame alive
    assign timeout  = (state_q != ST_IDLE) && (wd_q == WD_MAX) && !fe;

    always_comb begin
        state_d = state_q;
        byte_ok = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE:   if (fe && !data_s) state_d = ST_DATA;
            ST_DATA:   if (fe && bit_cnt == 3'd7) state_d = ST_PARITY;
            ST_PARITY: if (fe) state_d = ST_STOP;
            ST_STOP: begin
                if (fe) begin
                    state_d = ST_IDLE;
                    byte_ok = frame_ok;
                    err     = !frame_ok;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d = ST_IDLE;
            err     = 1'b1;
        end
    end

    // Frame stage: state, shift register, bit counter, parity, watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (fe && state_q == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (fe && state_q == ST_DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= {data_s, shift_q[7:1]};
            end
            if (fe && state_q == ST_PARITY) par_q <= data_s;
            if (fe || state_q == ST_IDLE) wd_q <= '0;
            else wd_q <= wd_sat_inc(wd_q);
        end
    end

    assign rx_byte = shift_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: turns E0/F0-prefixed scan-code frames into a
// held {brk, ext, scan} key code with a one-cycle valid strobe.
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int TIMEOUT     = 100_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] code,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    logic       byte_ok;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       ext;
    logic       brk;

    ps2_frame_rx #(
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_frame (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .byte_ok (byte_ok),
        .rx_byte (rx_byte),
        .err     (frame_err),
        .busy    (busy)
    );

    // Decode stage: prefix flags accumulate until a plain byte completes a key
    always_ff @(posedge clk) begin
        if (rst) begin
            code  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            ext   <= 1'b0;
            brk   <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= frame_err;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_ok) begin
                if (rx_byte == PS2_PREFIX_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == PS2_PREFIX_BRK) begin
                    brk <= 1'b1;
                end else begin
                    code  <= make_code(brk, ext, rx_byte);
                    valid <= 1'b1;
                    ext   <= 1'b0;
                    brk   <= 1'b0;
                end
            end
        end
    end

endmodule
